merged_depermutation_stream: RTL and testbench
==============================================

MERGED_DEPERMUTATION_STREAM -- requirements
Module: merged_depermutation_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the element width in bits.
REQ-002 SHALL have parameter SIZE, default 257, the buffer depth in elements.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port mode, input, 3 bits: the permutation to undo; sampled on the first accepted beat of each vector.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, WIDTH): the permuted-order input stream.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, WIDTH) and out_last (output, 1): the natural-order output stream.
REQ-008 SHALL have port err, output, 1 bit: a one-cycle pulse flagging an illegal mode.

Function
REQ-009 SHALL define the vector length N and beat k (0-based) mapped to buffer address A(k) per mode:
- Mode 0: N=257; A(k)=(k+1) mod 257.
- Mode 1: N=85, stride S=17.
- Mode 2: N=85, stride S=5.
- Modes 3-7: illegal.
REQ-010 SHALL, for modes 1 and 2:
- Beats k < N-N/S go to the k-th address in ascending order that is not a multiple of S.
- Tail beats go to S*(k-(N-N/S)), i.e. 80..84 for mode 1 and 68..84 for mode 2.
REQ-011 SHALL generate A(k) with counters only (a running pointer, a modulo-S skip counter and a tail pointer stepping by S), with no divider.
REQ-012 SHALL implement FSM states LOAD and DRAIN; in LOAD in_ready=1 and a beat is accepted when in_valid&&in_ready.
REQ-013 SHALL, on the beat that completes N accepted beats in cycle t, enter DRAIN with out_valid=1 in cycle t+1.
REQ-014 SHALL, in DRAIN, present out_data=mem[rd_ptr] for rd_ptr=0..N-1, advancing only on out_valid&&out_ready; out_data and out_valid SHALL hold stable while stalled.
REQ-015 SHALL assert out_last with the beat at rd_ptr=N-1; on that handshake it SHALL return to LOAD with counters cleared.
REQ-016 SHALL, when the first beat carries an illegal mode: accept and discard that beat, pulse err for the next cycle, write nothing and remain in LOAD at beat 0.
REQ-017 SHALL ignore changes on mode after the first beat until the vector completes.
REQ-018 SHALL, without DEPERM_PINGPONG_EN, hold in_ready=0 throughout DRAIN.

Reset
REQ-019 SHALL, on rst, immediately force state LOAD, all counters to 0, in_ready=0 while rst is high, and out_valid=0, out_last=0, err=0.
REQ-020 SHALL, on rst asserted mid-load or mid-drain, discard the partial vector; buffer contents are not cleared and are don't-care.
REQ-021 SHALL assert in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-022 SHALL use macro DEPERM_PINGPONG_EN: when defined, two SIZE-deep banks are built, and load of the next vector into one bank overlaps drain of the other.
REQ-023 SHALL, with DEPERM_PINGPONG_EN defined:
- in_ready=0 only when both banks hold complete undrained vectors.
- Drain order equals load order.
- Each bank keeps its own latched mode.
- A vector completing in the same cycle as the other bank's last out beat starts draining the next cycle with no gap.
REQ-024 SHALL, with DEPERM_PINGPONG_EN undefined, be single-bank and alternate strictly between LOAD and DRAIN.

Verification
REQ-025 Mode 0, in_data=k for k=0..256, out_ready=1 -> output 256,0,1,...,255; out_last on the 257th beat; out_valid first high the cycle after the last input.
REQ-026 Mode 1, in_data=k for k=0..84 -> output 80,0..15,81,16..31,82,32..47,83,48..63,84,64..79.
REQ-027 Mode 2, in_data=k -> output starts 68,0,1,2,3,69,4,5,6,7,70; the 85th beat is 67 with out_last=1.
REQ-028 Mode 0 with out_ready toggling 1-0-1 every cycle -> the same sequence as REQ-025, and out_data stable whenever out_valid&&!out_ready.
REQ-029 First beat with mode=5 -> err=1 for exactly one cycle and no out_valid; a following mode 2 vector -> correct REQ-027 output.
REQ-030 rst pulsed after 40 beats of mode 0 -> out_valid=0; a fresh mode 1 vector -> the REQ-026 output with no stale elements.

Source files
------------

// File: rtl/merged_depermutation_stream.sv
// merged_depermutation_stream: buffers one permuted vector, then streams it
// out in natural order. Write addresses are generated by counters only.
// Optional: define DEPERM_PINGPONG_EN for two banks, so that the load of the
// next vector overlaps the drain of the previous one.
module merged_depermutation_stream #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 257
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             err
);
    localparam int AW = $clog2(SIZE);
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] TWO = AW'(2);

    function automatic logic [AW-1:0] vec_len(input logic [2:0] m);
        case (m)
            3'd1, 3'd2: vec_len = AW'(85);
            default:    vec_len = AW'(257);
        endcase
    endfunction

    logic [2:0]    lmode_q, cur_mode;
    logic [AW-1:0] beat_q, ptr_q, skip_q, tail_q;
    logic [AW-1:0] n_w, head_w, s_w, wr_addr;
    logic          err_q, accept, legal, wr_en, last_in, in_tail;

    // Mode is taken live on beat 0 and from the latch afterwards. Mode 0 is
    // handled as stride 257: head beats fill 1..256 and one tail beat fills 0.
    always_comb begin
        cur_mode = (beat_q == '0) ? mode : lmode_q;
        case (cur_mode)
            3'd1:    begin head_w = AW'(80);  s_w = AW'(17);  end
            3'd2:    begin head_w = AW'(68);  s_w = AW'(5);   end
            default: begin head_w = AW'(256); s_w = AW'(257); end
        endcase
        n_w     = vec_len(cur_mode);
        legal   = cur_mode <= 3'd2;
        accept  = in_valid && in_ready;
        wr_en   = accept && legal;
        last_in = wr_en && (beat_q == n_w - ONE);
        in_tail = beat_q >= head_w;
        // ptr_q holds address-1 so that every counter clears to zero
        wr_addr = in_tail ? tail_q : ptr_q + ONE;
    end

    // Address generator: running pointer with a modulo-S skip, tail pointer stepping by S
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q  <= '0;
            ptr_q   <= '0;
            skip_q  <= '0;
            tail_q  <= '0;
            lmode_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            if (last_in) begin
                beat_q <= '0;
                ptr_q  <= '0;
                skip_q <= '0;
                tail_q <= '0;
            end else if (wr_en) begin
                beat_q <= beat_q + ONE;
                if (beat_q == '0) lmode_q <= mode;
                if (in_tail) begin
                    tail_q <= tail_q + s_w;
                end else if (skip_q == s_w - TWO) begin
                    // next address is a multiple of S: hop over it
                    ptr_q  <= ptr_q + TWO;
                    skip_q <= '0;
                end else begin
                    ptr_q  <= ptr_q + ONE;
                    skip_q <= skip_q + ONE;
                end
            end
        end
    end

    assign err = err_q;

`ifndef DEPERM_PINGPONG_EN
    typedef enum logic {LOAD, DRAIN} state_t;

    state_t           state_q;
    logic [AW-1:0]    rd_ptr_q, n_rd;
    logic             out_valid_q, out_last_q;
    logic [WIDTH-1:0] mem_q [SIZE];

    // Single bank: the latched mode cannot change while draining
    assign n_rd      = vec_len(lmode_q);
    assign in_ready  = (state_q == LOAD) && !rst;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = mem_q[rd_ptr_q];

    // LOAD/DRAIN sequencing with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (last_in) begin
                    state_q     <= DRAIN;
                    out_valid_q <= 1'b1;
                end
                DRAIN: if (out_ready) begin
                    if (out_last_q) begin
                        state_q     <= LOAD;
                        rd_ptr_q    <= '0;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end else begin
                        rd_ptr_q   <= rd_ptr_q + ONE;
                        out_last_q <= (rd_ptr_q + ONE == n_rd - ONE);
                    end
                end
            endcase
        end
    end

    // Buffer write; contents survive reset and are simply overwritten
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= in_data;
    end
`else
    logic [1:0]       full_q, full_d;
    logic             wb_q, rb_q, drain_done;
    logic [2:0]       bmode_q [2];
    logic [AW-1:0]    rd_ptr_q, n_rd;
    logic [WIDTH-1:0] mem_q [2][SIZE];

    // Banks are written and read in strict alternation, so drain order equals load order
    assign n_rd       = vec_len(bmode_q[rb_q]);
    assign in_ready   = !full_q[wb_q] && !rst;
    assign out_valid  = full_q[rb_q];
    assign out_last   = out_valid && (rd_ptr_q == n_rd - ONE);
    assign out_data   = mem_q[rb_q][rd_ptr_q];
    assign drain_done = out_valid && out_ready && out_last;

    // Fill and drain can retire different banks in the same cycle
    always_comb begin
        full_d = full_q;
        if (last_in)    full_d[wb_q] = 1'b1;
        if (drain_done) full_d[rb_q] = 1'b0;
    end

    // Bank bookkeeping: full flags, bank pointers, per-bank mode, read pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            rd_ptr_q   <= '0;
            bmode_q[0] <= '0;
            bmode_q[1] <= '0;
        end else begin
            full_q <= full_d;
            if (last_in) begin
                bmode_q[wb_q] <= cur_mode;
                wb_q          <= ~wb_q;
            end
            if (drain_done) begin
                rb_q     <= ~rb_q;
                rd_ptr_q <= '0;
            end else if (out_valid && out_ready) begin
                rd_ptr_q <= rd_ptr_q + ONE;
            end
        end
    end

    // Buffer write into the bank currently loading
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wb_q][wr_addr] <= in_data;
    end
`endif

endmodule

// File: tb/tb_merged_depermutation_stream.sv
// Scoreboard bench: stimulus pushes the hand-derived natural-order output
// sequence, and a negedge monitor pops and compares each output handshake.
module tb_merged_depermutation_stream;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   mode = 3'd0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready;
    logic         in_ready, out_valid, out_last, err;
    logic [W-1:0] out_data;

    int errors = 0;
    int checks = 0;
    logic [W:0] sb [$];
    bit toggle_en = 1'b0;
    logic stalled = 1'b0;
    logic [W-1:0] stall_data;
    logic [W:0] exp_e;

    always #5 clk = ~clk;

    merged_depermutation_stream #(.WIDTH(W), .SIZE(257)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // out_ready: held high, or toggled 1-0-1 every cycle when toggle_en
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = toggle_en ? ~out_ready : 1'b1;
        end
    end

    // Monitor: compare each output handshake against the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", out_data, stall_data);
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got out_valid=1 data=%0d expected no output", out_data);
                end else if (out_ready) begin
                    exp_e = sb.pop_front();
                    check("out_data", out_data, exp_e[W-1:0]);
                    check("out_last", 32'(out_last), 32'(exp_e[W]));
                end else begin
                    stalled    = 1'b1;
                    stall_data = out_data;
                end
            end
        end
    end

    task automatic send_beat(input logic [2:0] m, input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        mode     = m;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Later beats carry junk modes, which must be ignored
    task automatic send_vec(input logic [2:0] m, input int n);
        for (int k = 0; k < n; k++)
            send_beat((k == 0) ? m : 3'((k * 3) % 8), W'(k));
    endtask

    task automatic push_mode0;
        sb.push_back({1'b0, W'(256)});
        for (int k = 0; k < 256; k++) sb.push_back({(k == 255), W'(k)});
    endtask

    task automatic push_mode1;
        for (int g = 0; g < 5; g++) begin
            sb.push_back({1'b0, W'(80 + g)});
            for (int j = 0; j < 16; j++) sb.push_back({(g == 4 && j == 15), W'(16 * g + j)});
        end
    endtask

    task automatic push_mode2;
        for (int g = 0; g < 17; g++) begin
            sb.push_back({1'b0, W'(68 + g)});
            for (int j = 0; j < 4; j++) sb.push_back({(g == 16 && j == 3), W'(4 * g + j)});
        end
    endtask

    task automatic first_out_check(input string name);
        @(negedge clk);
        check(name, 32'(out_valid), 32'd1);
`ifndef DEPERM_PINGPONG_EN
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
`endif
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // mode 0, out_ready high
        send_vec(3'd0, 257);
        push_mode0();
        first_out_check("m0_valid_next_cycle");
        wait_drain("m0_drain");

        // mode 1
        send_vec(3'd1, 85);
        push_mode1();
        first_out_check("m1_valid_next_cycle");
        wait_drain("m1_drain");

        // mode 2
        send_vec(3'd2, 85);
        push_mode2();
        first_out_check("m2_valid_next_cycle");
        wait_drain("m2_drain");

        // mode 0 with out_ready toggling
        toggle_en = 1'b1;
        send_vec(3'd0, 257);
        push_mode0();
        wait_drain("m0_toggle_drain");
        toggle_en = 1'b0;
        @(posedge clk); #1;

        // illegal mode on the first beat, then a clean mode 2 vector
        send_beat(3'd5, W'(99));
        @(negedge clk);
        check("err_pulse", 32'(err), 32'd1);
        check("err_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("err_one_cycle", 32'(err), 32'd0);
        check("err_still_load", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send_vec(3'd2, 85);
        push_mode2();
        first_out_check("m2b_valid_next_cycle");
        wait_drain("m2b_drain");

        // reset after 40 beats of mode 0, then a fresh mode 1 vector
        send_vec(3'd0, 40);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        check("midrst_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send_vec(3'd1, 85);
        push_mode1();
        first_out_check("m1b_valid_next_cycle");
        wait_drain("m1b_drain");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
